// File: rtl/matrix_mult_pkg.sv
// Shared constants and FSM encoding for the 3x3 unsigned matrix multiplier.
package matrix_mult_pkg;
  localparam int DATA_W = 8;
  localparam int N      = 3;
  localparam int PROD_W = 16;
  localparam int SUM_W  = 18;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_e;
endpackage

// File: rtl/matrix_mult_dot3.sv
// One output element: registers three products, then their mod-256 sum.
module matrix_mult_dot3
  import matrix_mult_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mul_en,
  input  logic                        add_en,
  input  logic [N-1:0][DATA_W-1:0]    a_i,
  input  logic [N-1:0][DATA_W-1:0]    b_i,
  output logic [DATA_W-1:0]           sum_o
);
  logic [N-1:0][PROD_W-1:0] prod_q;
  logic [DATA_W-1:0]        sum_q;
  logic [SUM_W-1:0]         sum_full;
  logic                     unused_sum_hi;

  always_comb begin
    sum_full = '0;
    for (int k = 0; k < N; k++) sum_full = sum_full + SUM_W'(prod_q[k]);
  end

  // Only the low byte survives; the carry bits are deliberately discarded.
  assign unused_sum_hi = ^sum_full[SUM_W-1:DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      sum_q  <= '0;
    end else begin
      if (mul_en)
        for (int k = 0; k < N; k++) prod_q[k] <= PROD_W'(a_i[k]) * PROD_W'(b_i[k]);
      if (add_en) sum_q <= sum_full[DATA_W-1:0];
    end
  end

  assign sum_o = sum_q;
endmodule

// File: rtl/matrix_mult.sv
// 3x3 unsigned matrix multiply: capture once after reset, 3-cycle pipeline, hold result.
module matrix_mult
  import matrix_mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a0, a1, a2, a3, a4, a5, a6, a7, a8,
  input  logic [DATA_W-1:0] b0, b1, b2, b3, b4, b5, b6, b7, b8,
  output logic [DATA_W-1:0] c0, c1, c2, c3, c4, c5, c6, c7, c8,
  output logic              done
);
  state_e                          state_q, state_d;
  logic [N*N-1:0][DATA_W-1:0]      a_q, b_q, a_d, b_d, c_w;
  logic                            done_q;
  logic                            mul_en, add_en;

  assign a_d = {a8, a7, a6, a5, a4, a3, a2, a1, a0};
  assign b_d = {b8, b7, b6, b5, b4, b3, b2, b1, b0};

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    state_d = MUL;
      MUL:     state_d = ADD;
      ADD:     state_d = DONE;
      default: state_d = DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      a_q     <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == LOAD) begin
        a_q <= a_d;
        b_q <= b_d;
      end
      // done rises on the same edge the dot units register their sums.
      if (state_q == ADD) done_q <= 1'b1;
    end
  end

  assign mul_en = (state_q == MUL);
  assign add_en = (state_q == ADD);

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [N-1:0][DATA_W-1:0] arow, bcol;
      for (genvar k = 0; k < N; k++) begin : g_k
        assign arow[k] = a_q[i*N+k];
        assign bcol[k] = b_q[k*N+j];
      end
      matrix_mult_dot3 u_dot (
        .clk    (clk),
        .rst    (rst),
        .mul_en (mul_en),
        .add_en (add_en),
        .a_i    (arow),
        .b_i    (bcol),
        .sum_o  (c_w[i*N+j])
      );
    end
  end

  assign {c8, c7, c6, c5, c4, c3, c2, c1, c0} = c_w;
  assign done = done_q;
endmodule

// File: tb/tb_matrix_mult.sv
// Randomized self-checking bench for matrix_mult against a behavioural matrix model.
module tb_matrix_mult;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a [9];
  logic [7:0] b [9];
  logic [7:0] c [9];
  logic       done;
  int         n_pass = 0;
  int         n_tot  = 0;

  always #5 clk = ~clk;

  matrix_mult dut (
    .clk(clk), .rst(rst),
    .a0(a[0]), .a1(a[1]), .a2(a[2]), .a3(a[3]), .a4(a[4]), .a5(a[5]), .a6(a[6]), .a7(a[7]), .a8(a[8]),
    .b0(b[0]), .b1(b[1]), .b2(b[2]), .b3(b[3]), .b4(b[4]), .b5(b[5]), .b6(b[6]), .b7(b[7]), .b8(b[8]),
    .c0(c[0]), .c1(c[1]), .c2(c[2]), .c3(c[3]), .c4(c[4]), .c5(c[5]), .c6(c[6]), .c7(c[7]), .c8(c[8]),
    .done(done)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Model: cycles since reset release, and the matrices seen on the first such edge.
  int         m_cyc = 0;
  logic [7:0] ca [9];
  logic [7:0] cb [9];

  always @(posedge clk) begin
    if (rst) m_cyc <= 0;
    else begin
      if (m_cyc < 3) m_cyc <= m_cyc + 1;
      if (m_cyc == 0) begin
        ca <= a;
        cb <= b;
      end
    end
  end

  function automatic int ref_c(input int i, input int j);
    int s = 0;
    for (int k = 0; k < 3; k++) s += int'(ca[3*i+k]) * int'(cb[3*k+j]);
    return s % 256;
  endfunction

  always @(negedge clk) begin
    chk("done", int'(done), (m_cyc >= 3) ? 1 : 0);
    for (int i = 0; i < 9; i++)
      chk($sformatf("c%0d", i), int'(c[i]), (m_cyc >= 3) ? ref_c(i / 3, i % 3) : 0);
  end

  task automatic rand_in();
    for (int i = 0; i < 9; i++) begin
      a[i] = 8'($urandom);
      b[i] = 8'($urandom);
    end
  endtask

  task automatic start(input int hold);
    rst = 1'b1;
    repeat (hold) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_lit(input string nm, input int e [9]);
    for (int i = 0; i < 9; i++) chk($sformatf("%s_c%0d", nm, i), int'(c[i]), e[i]);
  endtask

  int exp9 [9];

  initial begin
    rand_in();
    for (int i = 0; i < 9; i++) a[i] = a[i] | 8'h01;
    repeat (5) @(negedge clk);

    // Reference product with exact latency.
    for (int i = 0; i < 9; i++) begin
      a[i] = 8'(i + 1);
      b[i] = 8'(9 - i);
    end
    start(1);
    @(negedge clk); chk("ref_done_e1", int'(done), 0);
    @(negedge clk); chk("ref_done_e2", int'(done), 0);
    @(negedge clk); chk("ref_done_e3", int'(done), 1);
    exp9 = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
    chk_lit("ref", exp9);

    // Overflow wraps mod 256.
    for (int i = 0; i < 9; i++) begin
      a[i] = 8'hFF;
      b[i] = 8'hFF;
    end
    start(1);
    repeat (3) @(negedge clk);
    exp9 = '{3, 3, 3, 3, 3, 3, 3, 3, 3};
    chk_lit("ovf", exp9);
    chk("ovf_done", int'(done), 1);

    // Identity on the left, then on the right.
    for (int i = 0; i < 9; i++) begin
      a[i] = (i % 4 == 0) ? 8'd1 : 8'd0;
      b[i] = 8'(9 - i);
    end
    start(2);
    repeat (3) @(negedge clk);
    exp9 = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
    chk_lit("idl", exp9);
    for (int i = 0; i < 9; i++) begin
      a[i] = 8'($urandom);
      b[i] = (i % 4 == 0) ? 8'd1 : 8'd0;
      exp9[i] = int'(a[i]);
    end
    start(1);
    repeat (3) @(negedge clk);
    chk_lit("idr", exp9);

    // Input freeze: A zeroed after capture, then everything churned after done.
    rand_in();
    start(1);
    @(negedge clk);
    for (int i = 0; i < 9; i++) a[i] = 8'd0;
    repeat (2) @(negedge clk);
    chk("frz_done", int'(done), 1);
    repeat (20) begin
      rand_in();
      @(negedge clk);
    end

    // Reset asserted in ADD aborts on the E3 edge.
    rand_in();
    start(1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_done", int'(done), 0);
    chk("mid_c0", int'(c[0]), 0);
    rand_in();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_redone", int'(done), 1);

    // Random matrices with varied reset lengths.
    repeat (15) begin
      rand_in();
      start(int'($urandom_range(1, 3)));
      repeat (4) begin
        @(negedge clk);
        rand_in();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
